// File: rtl/sm_keypad_scanner_if.sv
// sm_keypad_scanner_if: keypad matrix pins and key-event outputs of the keypad scanner.
interface sm_keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_held;
  modport master (input col_n, output row_n, key_code, key_valid, key_release, key_held);
  modport slave (output col_n, input row_n, key_code, key_valid, key_release, key_held);
endinterface

// File: rtl/sm_keypad_scanner.sv
// sm_keypad_scanner: 4x4 keypad row scanner with whole-frame debounce and single-key press/release events.
module sm_keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input logic                clk,
  input logic                rst,
  sm_keypad_scanner_if.master kp
);
  localparam int DW = SCAN_DIV > 2 ? $clog2(SCAN_DIV) : 1;
  localparam int RW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;
  logic [3:0] c1_q, cs_q, row_n_q, row_n_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] row_q, row_d;
  logic [15:0] frame_q, frame_d, last_q, last_d;
  logic [RW-1:0] run_q, run_d;
  state_t state_q, state_d;
  logic [3:0] code_q, code_d, idx;
  logic valid_q, valid_d, rel_q, rel_d, held_q, held_d;
  logic sample, frame_end, accept, onehot, empty;
  assign sample = div_q == DW'(SCAN_DIV - 1);
  assign frame_end = sample && row_q == 2'd3;
  // frame_d already holds the row-3 nibble on the frame-end edge
  always_comb begin
    div_d = sample ? '0 : div_q + DW'(1);
    row_d = sample ? row_q + 2'd1 : row_q;
    row_n_d = ~(4'b0001 << row_d);
    frame_d = frame_q;
    if (sample) frame_d[{row_q, 2'b00} +: 4] = ~cs_q;
    run_d = !frame_end ? run_q :
            frame_d != last_q ? RW'(1) :
            run_q == RW'(DEBOUNCE) ? run_q : run_q + RW'(1);
    last_d = frame_end ? frame_d : last_q;
    accept = frame_end && run_d == RW'(DEBOUNCE) && (run_q != RW'(DEBOUNCE) || frame_d != last_q);
    empty = frame_d == 16'd0;
    onehot = !empty && (frame_d & (frame_d - 16'd1)) == 16'd0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) if (frame_d[i]) idx = 4'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= 4'hF;
      cs_q <= 4'hF;
      div_q <= '0;
      row_q <= 2'd0;
      row_n_q <= 4'b1110;
      frame_q <= '0;
      last_q <= '0;
      run_q <= '0;
      state_q <= IDLE;
      code_q <= 4'd0;
      valid_q <= 1'b0;
      rel_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      c1_q <= kp.col_n;
      cs_q <= c1_q;
      div_q <= div_d;
      row_q <= row_d;
      row_n_q <= row_n_d;
      frame_q <= frame_d;
      last_q <= last_d;
      run_q <= run_d;
      state_q <= state_d;
      code_q <= code_d;
      valid_q <= valid_d;
      rel_q <= rel_d;
      held_q <= held_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = !accept || empty ? IDLE : onehot ? HELD : LOCK;
      HELD: state_d = !accept ? HELD : empty ? IDLE : frame_d != (16'd1 << code_q) ? LOCK : HELD;
      LOCK: state_d = accept && empty ? IDLE : LOCK;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    valid_d = accept && state_q == IDLE && onehot;
    rel_d = accept && state_q == HELD && empty;
    held_d = state_d == HELD;
    code_d = valid_d ? idx : code_q;
  end
  assign kp.row_n = row_n_q;
  assign kp.key_code = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_release = rel_q;
  assign kp.key_held = held_q;
endmodule

// File: tb/tb_sm_keypad_scanner.sv
// tb_sm_keypad_scanner: keypad matrix model, event scoreboard, vector table and timing/reset sequences.
module tb_sm_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keys = 16'h0000;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          ev;
    logic [3:0]  code;
    logic        held;
  } vec_t;
  typedef struct {
    int         ev;
    logic [3:0] code;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  sm_keypad_scanner_if kp ();
  sm_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (.clk(clk), .rst(rst), .kp(kp));
  always_comb begin
    kp.col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.row_n[r]) kp.col_n[c] = 1'b0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic push(input int ev, input logic [3:0] code);
    exp_t e;
    e.ev = ev;
    e.code = code;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (kp.key_valid === 1'b1 || kp.key_release === 1'b1) begin
      chk("pulse_exclusive", 32'(kp.key_valid & kp.key_release), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%b release=%b code=%h expected no pulse",
                 kp.key_valid, kp.key_release, kp.key_code);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", kp.key_valid ? 32'd1 : 32'd2, 32'(e.ev));
        chk("pulse_code", 32'(kp.key_code), 32'(e.code));
      end
    end
  end
  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic wait_valid(output int c);
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) break;
      c++;
    end
  endtask
  initial begin
    vec_t vt[8];
    int c;
    logic [3:0] er;
    vt[0] = '{16'h0000, 5, 2, 4'h9, 1'b0};
    vt[1] = '{16'h0021, 5, 0, 4'h9, 1'b0};
    vt[2] = '{16'h0000, 5, 0, 4'h9, 1'b0};
    vt[3] = '{16'h8000, 5, 1, 4'hF, 1'b1};
    vt[4] = '{16'h8008, 5, 0, 4'hF, 1'b0};
    vt[5] = '{16'h0000, 5, 0, 4'hF, 1'b0};
    vt[6] = '{16'h0040, 5, 1, 4'h6, 1'b1};
    vt[7] = '{16'h0000, 5, 2, 4'h6, 1'b0};
    do_reset();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rst_key_code", 32'(kp.key_code), 32'd0);
        chk("rst_key_valid", 32'(kp.key_valid), 32'd0);
        chk("rst_key_release", 32'(kp.key_release), 32'd0);
        chk("rst_key_held", 32'(kp.key_held), 32'd0);
      end
      er = ~(4'b0001 << ((i / 4) % 4));
      chk("row_seq", 32'(kp.row_n), 32'(er));
    end
    do_reset();
    keys = 16'h0200;
    push(1, 4'h9);
    wait_valid(c);
    chk("valid_latency", 32'(c), 32'd48);
    chk("press_held", 32'(kp.key_held), 32'd1);
    chk("press_code", 32'(kp.key_code), 32'h9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("midrst_row_n", 32'(kp.row_n), 32'hE);
    chk("midrst_held", 32'(kp.key_held), 32'd0);
    chk("midrst_code", 32'(kp.key_code), 32'd0);
    chk("midrst_valid", 32'(kp.key_valid), 32'd0);
    push(1, 4'h9);
    wait_valid(c);
    chk("revalid_latency", 32'(c + 1), 32'd48);
    chk("revalid_code", 32'(kp.key_code), 32'h9);
    for (int v = 0; v < 8; v++) begin
      if (vt[v].ev != 0) push(vt[v].ev, vt[v].code);
      keys = vt[v].keys;
      repeat (vt[v].frames * 16) @(posedge clk);
      @(negedge clk);
      chk("vec_held", 32'(kp.key_held), 32'(vt[v].held));
      chk("vec_code", 32'(kp.key_code), 32'(vt[v].code));
      chk("vec_pending", 32'(exp_q.size()), 32'd0);
    end
    for (int t = 0; t < 10; t++) begin
      keys = keys ^ 16'h0200;
      repeat (20) @(posedge clk);
    end
    keys = 16'h0000;
    repeat (6 * 16) @(posedge clk);
    @(negedge clk);
    chk("bounce_held", 32'(kp.key_held), 32'd0);
    chk("bounce_code", 32'(kp.key_code), 32'h6);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
